// File: rtl/mx_bus_pkg.sv
// Shared definitions for the MX bus arbiters: FSM state encoding, master indices
// and the watchdog counter width.
package mx_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT,
    ARB_BUSY
  } arb_state_t;

  localparam int MX_M_INS  = 0;
  localparam int MX_M_DATA = 1;

  localparam int WD_WIDTH = 16;

endpackage

// File: rtl/mx_rr_pick2.sv
// Two-requester picker: round-robin against the last owner when rr_en is set,
// otherwise requester 0 has fixed priority. Purely combinational.
module mx_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      // On a tie, the master that did not own the port last time goes next.
      2'b11:   pick = (rr_en && !last) ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/mx_rd_arbiter.sv
// Two-master read-channel arbiter for the MX bus: instruction fetch (M0) and data (M1)
// share one slave read port, with per-transaction grants and a hung-slave watchdog.
module mx_rd_arbiter
  import mx_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter bit ROUND_ROBIN    = 1'b1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_rd_txn_start,
  input  logic [ADDR_WIDTH-1:0] m0_rd_addr,
  output logic [DATA_WIDTH-1:0] m0_rd_data,
  output logic                  m0_rd_ready,
  output logic                  m0_rd_txn_ack,
  output logic                  m0_rd_txn_cpl,
  input  logic                  m1_rd_txn_start,
  input  logic [ADDR_WIDTH-1:0] m1_rd_addr,
  output logic [DATA_WIDTH-1:0] m1_rd_data,
  output logic                  m1_rd_ready,
  output logic                  m1_rd_txn_ack,
  output logic                  m1_rd_txn_cpl,
  output logic                  s_rd_txn_start,
  output logic [ADDR_WIDTH-1:0] s_rd_addr,
  input  logic [DATA_WIDTH-1:0] s_rd_data,
  input  logic                  s_rd_ready,
  input  logic                  s_rd_txn_ack,
  input  logic                  s_rd_txn_cpl,
  output logic [1:0]            grant,
  output logic                  timeout_err
);

  localparam bit                  WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_EN ? WD_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_t              state_reg, state_next;
  logic [1:0]              grant_reg, grant_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic                    last_reg, last_next;
  logic [WD_WIDTH-1:0]     wd_cnt_reg, wd_cnt_next;

  logic [1:0]              req;
  logic [1:0]              pick;
  logic                    owner;
  logic                    wd_expired;
  logic                    fwd_ack;
  logic                    fwd_cpl;
  logic                    fwd_data_en;
  logic                    abort;

  assign req        = {m1_rd_txn_start, m0_rd_txn_start};
  assign owner      = grant_reg[MX_M_DATA];
  assign wd_expired = WD_EN && (wd_cnt_reg == WD_LIMIT);

  mx_rr_pick2 u_pick (
    .req   (req),
    .last  (last_reg),
    .rr_en (ROUND_ROBIN),
    .pick  (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ARB_IDLE;
      grant_reg  <= 2'b00;
      addr_reg   <= '0;
      last_reg   <= 1'(MX_M_DATA);
      wd_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      addr_reg   <= addr_next;
      last_reg   <= last_next;
      wd_cnt_reg <= wd_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    addr_next   = addr_reg;
    last_next   = last_reg;
    wd_cnt_next = wd_cnt_reg;
    fwd_ack     = 1'b0;
    fwd_cpl     = 1'b0;
    fwd_data_en = 1'b0;
    abort       = 1'b0;

    case (state_reg)
      ARB_IDLE: begin
        // Late slave strobes are ignored here; only a new request moves the FSM.
        if (|pick) begin
          grant_next  = pick;
          addr_next   = pick[MX_M_DATA] ? m1_rd_addr : m0_rd_addr;
          wd_cnt_next = '0;
          state_next  = ARB_GNT;
        end
      end

      ARB_GNT: begin
        wd_cnt_next = wd_cnt_reg + 1'b1;
        if (wd_expired && !(s_rd_txn_ack && s_rd_txn_cpl)) begin
          // The owner never saw an ack, so it gets ack and cpl together to unblock it.
          abort   = 1'b1;
          fwd_ack = 1'b1;
          fwd_cpl = 1'b1;
        end else if (s_rd_txn_ack) begin
          fwd_ack     = 1'b1;
          fwd_data_en = 1'b1;
          if (s_rd_txn_cpl) begin
            fwd_cpl    = 1'b1;
            state_next = ARB_IDLE;
            grant_next = 2'b00;
            last_next  = owner;
          end else begin
            state_next = ARB_BUSY;
          end
        end
      end

      ARB_BUSY: begin
        wd_cnt_next = wd_cnt_reg + 1'b1;
        if (s_rd_txn_cpl) begin
          fwd_data_en = 1'b1;
          fwd_cpl     = 1'b1;
          state_next  = ARB_IDLE;
          grant_next  = 2'b00;
          last_next   = owner;
        end else if (wd_expired) begin
          abort   = 1'b1;
          fwd_cpl = 1'b1;
        end else begin
          fwd_data_en = 1'b1;
        end
      end

      default: begin
        state_next = ARB_IDLE;
        grant_next = 2'b00;
      end
    endcase

    if (abort) begin
      state_next = ARB_IDLE;
      grant_next = 2'b00;
      last_next  = owner;
    end
  end

  assign s_rd_txn_start = (state_reg == ARB_GNT);
  assign s_rd_addr      = addr_reg;
  assign grant          = grant_reg;
  assign timeout_err    = abort;

  // Response demux: only the current owner ever sees a non-zero response.
  logic [1:0]            m_ack;
  logic [1:0]            m_cpl;
  logic [1:0]            m_ready;
  logic [DATA_WIDTH-1:0] m_data [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign m_ack[gi]   = fwd_ack & grant_reg[gi];
    assign m_cpl[gi]   = fwd_cpl & grant_reg[gi];
    assign m_ready[gi] = fwd_data_en & grant_reg[gi] & s_rd_ready;
    assign m_data[gi]  = (fwd_data_en & grant_reg[gi]) ? s_rd_data : '0;
  end

  assign m0_rd_txn_ack = m_ack[MX_M_INS];
  assign m0_rd_txn_cpl = m_cpl[MX_M_INS];
  assign m0_rd_ready   = m_ready[MX_M_INS];
  assign m0_rd_data    = m_data[MX_M_INS];
  assign m1_rd_txn_ack = m_ack[MX_M_DATA];
  assign m1_rd_txn_cpl = m_cpl[MX_M_DATA];
  assign m1_rd_ready   = m_ready[MX_M_DATA];
  assign m1_rd_data    = m_data[MX_M_DATA];

endmodule

// File: tb/tb_mx_rd_arbiter.sv
// Bench for mx_rd_arbiter: a round-robin instance and a fixed-priority instance share
// all inputs; a transaction-level model predicts owner, address and response timing.
module tb_mx_rd_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] m_start;
  logic [7:0] m_addr [2];
  logic [7:0] s_data;
  logic       s_ready, s_ack, s_cpl;

  logic [7:0] a_mdata [2];
  logic [1:0] a_mready, a_mack, a_mcpl, a_grant;
  logic       a_s_start, a_terr;
  logic [7:0] a_s_addr;

  logic [7:0] b_mdata [2];
  logic [1:0] b_mready, b_mack, b_mcpl, b_grant;
  logic       b_s_start, b_terr;
  logic [7:0] b_s_addr;

  int         pass_cnt = 0;
  int         chk_cnt  = 0;
  int         txn_no   = 0;
  int         model_last;
  logic [1:0] pend;

  mx_rd_arbiter #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(8)
  ) dut_a (
    .clk(clk), .rst(rst),
    .m0_rd_txn_start(m_start[0]), .m0_rd_addr(m_addr[0]), .m0_rd_data(a_mdata[0]),
    .m0_rd_ready(a_mready[0]), .m0_rd_txn_ack(a_mack[0]), .m0_rd_txn_cpl(a_mcpl[0]),
    .m1_rd_txn_start(m_start[1]), .m1_rd_addr(m_addr[1]), .m1_rd_data(a_mdata[1]),
    .m1_rd_ready(a_mready[1]), .m1_rd_txn_ack(a_mack[1]), .m1_rd_txn_cpl(a_mcpl[1]),
    .s_rd_txn_start(a_s_start), .s_rd_addr(a_s_addr), .s_rd_data(s_data),
    .s_rd_ready(s_ready), .s_rd_txn_ack(s_ack), .s_rd_txn_cpl(s_cpl),
    .grant(a_grant), .timeout_err(a_terr)
  );

  mx_rd_arbiter #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(8)
  ) dut_b (
    .clk(clk), .rst(rst),
    .m0_rd_txn_start(m_start[0]), .m0_rd_addr(m_addr[0]), .m0_rd_data(b_mdata[0]),
    .m0_rd_ready(b_mready[0]), .m0_rd_txn_ack(b_mack[0]), .m0_rd_txn_cpl(b_mcpl[0]),
    .m1_rd_txn_start(m_start[1]), .m1_rd_addr(m_addr[1]), .m1_rd_data(b_mdata[1]),
    .m1_rd_ready(b_mready[1]), .m1_rd_txn_ack(b_mack[1]), .m1_rd_txn_cpl(b_mcpl[1]),
    .s_rd_txn_start(b_s_start), .s_rd_addr(b_s_addr), .s_rd_data(s_data),
    .s_rd_ready(s_ready), .s_rd_txn_ack(s_ack), .s_rd_txn_cpl(s_cpl),
    .grant(b_grant), .timeout_err(b_terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arbitration rule: a lone requester wins; on a tie RR picks the other master, else M0.
  function automatic int pick_model(input logic [1:0] r, input int last, input bit rr);
    if (r == 2'b11) return rr ? (1 - last) : 0;
    return r[1] ? 1 : 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered and left at a drive point (posedge+1) of a cycle in which the arbiter is idle.
  task automatic run_txn(input logic [1:0] req_new, input logic [7:0] ad0, input logic [7:0] ad1,
                         input int ack_l, input int rdy_l, input int cpl_l, input logic [7:0] dat,
                         input bit hold_all, input bit chk_b);
    int         win, bwin;
    logic [1:0] oh, boh;
    logic [7:0] exp_addr, bexp_addr;
    logic [25:0] exp_v, act_v;
    bit         se, ae, ce, re;
    if (!pend[0] && req_new[0]) m_addr[0] = ad0;
    if (!pend[1] && req_new[1]) m_addr[1] = ad1;
    pend    = pend | req_new;
    m_start = pend;
    s_ack = 1'b0; s_cpl = 1'b0; s_ready = 1'b0; s_data = 8'($urandom);
    #1;
    chk_cnt++;
    if ({a_grant, a_s_start} !== 3'b000)
      $display("FAIL idle_gap txn %0d: grant/start got %b exp 000", txn_no, {a_grant, a_s_start});
    else pass_cnt++;
    win       = pick_model(pend, model_last, 1'b1);
    bwin      = pick_model(pend, 0, 1'b0);
    oh        = (win == 1) ? 2'b10 : 2'b01;
    boh       = (bwin == 1) ? 2'b10 : 2'b01;
    exp_addr  = m_addr[win];
    bexp_addr = m_addr[bwin];
    tick();
    for (int k = 0; k <= cpl_l; k++) begin
      if (k > ack_l && !hold_all) pend[win] = 1'b0;
      m_start = pend;
      s_ack   = (k == ack_l);
      s_cpl   = (k == cpl_l);
      s_ready = (k == rdy_l);
      s_data  = (k == rdy_l) ? dat : 8'($urandom);
      #1;
      se = (k <= ack_l); ae = (k == ack_l); ce = (k == cpl_l); re = (k == rdy_l);
      exp_v = {se, exp_addr, oh, ae ? oh : 2'b00, ce ? oh : 2'b00, re ? oh : 2'b00, 1'b0, 8'h00};
      act_v = {a_s_start, a_s_addr, a_grant, a_mack, a_mcpl, a_mready, a_terr, a_mdata[1-win]};
      chk_cnt++;
      if (act_v !== exp_v)
        $display("FAIL rr_txn %0d k=%0d: got %h exp %h", txn_no, k, act_v, exp_v);
      else pass_cnt++;
      if (re) begin
        chk_cnt++;
        if (a_mdata[win] !== dat)
          $display("FAIL rr_data txn %0d: got %h exp %h", txn_no, a_mdata[win], dat);
        else pass_cnt++;
      end
      if (chk_b) begin
        exp_v = {se, bexp_addr, boh, ae ? boh : 2'b00, ce ? boh : 2'b00, re ? boh : 2'b00, 1'b0, 8'h00};
        act_v = {b_s_start, b_s_addr, b_grant, b_mack, b_mcpl, b_mready, b_terr, b_mdata[1-bwin]};
        chk_cnt++;
        if (act_v !== exp_v)
          $display("FAIL fp_txn %0d k=%0d: got %h exp %h", txn_no, k, act_v, exp_v);
        else pass_cnt++;
      end
      tick();
    end
    if (!hold_all) pend[win] = 1'b0;
    model_last = win;
    $display("txn %0d: owner M%0d addr %02h data %02h ack@%0d rdy@%0d cpl@%0d", txn_no, win,
             exp_addr, dat, ack_l, rdy_l, cpl_l);
    txn_no++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pend = 2'b11;
    m_addr[0] = 8'($urandom); m_addr[1] = 8'($urandom);
    m_start = pend;
    s_ack = 1'b0; s_cpl = 1'b0; s_ready = 1'b0; s_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++;
      if ({a_s_start, a_s_addr, a_grant, a_mack, a_mcpl, a_mready, a_terr, a_mdata[0], a_mdata[1]} !== '0)
        $display("FAIL reset_outputs cycle %0d: grant %b start %b addr %h got nonzero exp 0",
                 i, a_grant, a_s_start, a_s_addr);
      else pass_cnt++;
    end
    rst = 1'b0;
    tick();
    chk_cnt++;
    if ({a_grant, a_s_start, a_s_addr} !== {2'b01, 1'b1, m_addr[0]})
      $display("FAIL reset_first_grant: got %b/%b/%h exp 01/1/%h", a_grant, a_s_start, a_s_addr, m_addr[0]);
    else pass_cnt++;
    s_ack = 1'b1; s_cpl = 1'b1;
    #1;
    chk_cnt++;
    if ({a_mack, a_mcpl, a_mready} !== 6'b01_01_00)
      $display("FAIL reset_first_cpl: ack/cpl/ready got %b exp 010100", {a_mack, a_mcpl, a_mready});
    else pass_cnt++;
    $display("txn %0d: reset then tie, owner M0 addr %02h", txn_no, m_addr[0]);
    txn_no++;
    model_last = 0;
    tick();
    pend = 2'b00; m_start = pend; s_ack = 1'b0; s_cpl = 1'b0;
  endtask

  task automatic test_single_m1;
    run_txn(2'b10, 8'h00, 8'h42, 2, 4, 5, 8'hA5, 1'b0, 1'b0);
  endtask

  task automatic test_same_cycle;
    int l;
    for (int i = 0; i < 3; i++) begin
      l = int'($urandom_range(0, 3));
      run_txn(($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, 8'($urandom), 8'($urandom),
              l, l, l, 8'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic test_contention;
    int al, cl;
    pend = 2'b00;
    for (int i = 0; i < 8; i++) begin
      al = int'($urandom_range(0, 2));
      cl = al + int'($urandom_range(0, 3));
      run_txn(2'b11, 8'h10, 8'h20, al, int'($urandom_range(al, cl)), cl, 8'($urandom), 1'b1, 1'b1);
    end
    pend = 2'b00;
  endtask

  task automatic test_random;
    int         al, cl;
    logic [1:0] rn;
    for (int i = 0; i < 20; i++) begin
      rn = 2'($urandom_range(0, 3));
      if ((pend | rn) == 2'b00) rn = 2'b01;
      al = int'($urandom_range(0, 2));
      cl = al + int'($urandom_range(0, 3));
      run_txn(rn, 8'($urandom), 8'($urandom), al, int'($urandom_range(al, cl)), cl,
              8'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic test_timeout(input bit in_busy);
    logic [25:0] exp_v, act_v;
    bit          se, ae, ce;
    pend = 2'b01;
    m_addr[0] = 8'($urandom);
    m_start = pend;
    s_ack = 1'b0; s_cpl = 1'b0; s_ready = 1'b0;
    #1;
    tick();
    for (int k = 0; k < 8; k++) begin
      if (in_busy && k > 1) pend[0] = 1'b0;
      m_start = pend;
      s_ack   = in_busy && (k == 1);
      s_cpl   = 1'b0;
      s_ready = (k == 7);
      s_data  = 8'($urandom);
      #1;
      se = in_busy ? (k <= 1) : 1'b1;
      ae = in_busy ? (k == 1) : (k == 7);
      ce = (k == 7);
      exp_v = {se, m_addr[0], 2'b01, ae ? 2'b01 : 2'b00, ce ? 2'b01 : 2'b00, 2'b00, ce, 8'h00};
      act_v = {a_s_start, a_s_addr, a_grant, a_mack, a_mcpl, a_mready, a_terr, a_mdata[1]};
      chk_cnt++;
      if (act_v !== exp_v)
        $display("FAIL timeout busy=%0d k=%0d: got %h exp %h", in_busy, k, act_v, exp_v);
      else pass_cnt++;
      tick();
    end
    pend = 2'b00; m_start = pend; model_last = 0;
    s_ack = 1'b1; s_cpl = 1'b1; s_ready = 1'b1;
    #1;
    chk_cnt++;
    if ({a_s_start, a_grant, a_mack, a_mcpl, a_mready, a_terr, a_mdata[0], a_mdata[1]} !== '0)
      $display("FAIL late_strobes busy=%0d: grant %b ack %b cpl %b got nonzero exp 0",
               in_busy, a_grant, a_mack, a_mcpl);
    else pass_cnt++;
    $display("txn %0d: timeout abort in %s, owner M0 addr %02h", txn_no, in_busy ? "BUSY" : "GNT", m_addr[0]);
    txn_no++;
    tick();
    s_ack = 1'b0; s_cpl = 1'b0; s_ready = 1'b0;
  endtask

  task automatic test_reset_busy;
    pend = 2'b10;
    m_addr[1] = 8'($urandom);
    m_start = pend;
    s_ack = 1'b0; s_cpl = 1'b0; s_ready = 1'b0;
    #1;
    tick();
    s_ack = 1'b1;
    #1;
    chk_cnt++;
    if (a_mack !== 2'b10) $display("FAIL rstbusy_ack: got %b exp 10", a_mack);
    else pass_cnt++;
    tick();
    s_ack = 1'b0; pend = 2'b00; m_start = pend; rst = 1'b1;
    #1;
    chk_cnt++;
    if ({a_grant, a_s_start} !== 3'b100)
      $display("FAIL rstbusy_owner: grant/start got %b exp 100", {a_grant, a_s_start});
    else pass_cnt++;
    tick();
    rst = 1'b0; s_cpl = 1'b1; s_ready = 1'b1; s_data = 8'($urandom);
    #1;
    chk_cnt++;
    if ({a_s_start, a_grant, a_mack, a_mcpl, a_mready, a_terr, a_mdata[0], a_mdata[1]} !== '0)
      $display("FAIL rstbusy_after: start %b grant %b cpl %b got nonzero exp 0", a_s_start, a_grant, a_mcpl);
    else pass_cnt++;
    $display("txn %0d: reset in BUSY, owner M1 addr %02h dropped", txn_no, m_addr[1]);
    txn_no++;
    model_last = 1;
    tick();
    s_cpl = 1'b0; s_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_m1();
    test_same_cycle();
    test_contention();
    test_random();
    test_timeout(1'b0);
    run_txn(2'b01, 8'($urandom), 8'h00, 1, 2, 3, 8'($urandom), 1'b0, 1'b0);
    test_timeout(1'b1);
    run_txn(2'b10, 8'h00, 8'($urandom), 0, 1, 2, 8'($urandom), 1'b0, 1'b0);
    test_reset_busy();
    run_txn(2'b11, 8'($urandom), 8'($urandom), 1, 1, 2, 8'($urandom), 1'b0, 1'b0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
